// File: rtl/aes_seq_pkg.sv
// ---------------------------------------------------------------------------
// aes_seq_pkg
// Shared definitions for the AES round sequencer and the PE array it drives:
//   - state_t     : sequencer FSM states
//   - OP_*        : op_sel encodings understood by every PE
//   - NR_AES128   : round count for AES-128
//   - pe_ctrl_t   : bundle of the shared array control lines
//   - key_index() : maps the key step to the key-store index for a direction
// ---------------------------------------------------------------------------
package aes_seq_pkg;

    localparam int NR_AES128 = 10;

    // PE operation codes; the PE decodes exactly these values.
    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_XOR    = 2'b01;
    localparam logic [1:0] OP_MIXCOL = 2'b10;
    localparam logic [1:0] OP_PASS   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KREQ,
        ST_KWAIT,
        ST_ARK,
        ST_SUBSH,
        ST_MIXC,
        ST_DONE
    } state_t;

    // Array control lines as one bundle so the decode can default them in
    // a single assignment.
    typedef struct packed {
        logic       pe_en;
        logic [1:0] op_sel;
        logic       load_psum;
        logic       shift_in_en;
    } pe_ctrl_t;

    // Encryption walks the schedule forwards (k0..kNR), decryption walks it
    // backwards (kNR..k0); the key step counter always counts up.
    function automatic logic [3:0] key_index(input logic       enc,
                                             input logic [3:0] ks,
                                             input logic [3:0] nr);
        return enc ? ks : 4'(nr - ks);
    endfunction

endpackage

// File: rtl/aes_key_fetch.sv
// ---------------------------------------------------------------------------
// aes_key_fetch
// Request/valid handshake with the FeRAM round-key store.
//   clk, rst_n : clock, asynchronous active-low reset
//   go         : the sequencer enters its request cycle on the next edge
//   addr       : round-key index to request (sampled with go)
//   key_vld    : key store reports key bytes on the array lines
//   key_req    : registered one-cycle request strobe
//   key_addr   : registered key index, valid while key_req is high
//   got        : key arrived while waiting (combinational)
//   timeout    : last wait cycle elapsed with no key (combinational)
// The wait window opens the cycle after key_req, so a key_vld seen during
// the request cycle itself never counts as an answer.
// ---------------------------------------------------------------------------
module aes_key_fetch #(
    parameter int KEY_TO = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [3:0] addr,
    input  logic       key_vld,
    output logic       key_req,
    output logic [3:0] key_addr,
    output logic       got,
    output logic       timeout
);

    localparam int              CW       = (KEY_TO > 1) ? $clog2(KEY_TO) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(KEY_TO - 1);

    logic          waiting_reg;
    logic [CW-1:0] cnt_reg;

    assign got     = waiting_reg & key_vld;
    // The counter holds the index of the current wait cycle, so the final
    // permitted cycle is KEY_TO-1; leaving from it puts err KEY_TO edges
    // after the wait began.
    assign timeout = waiting_reg & ~key_vld & (cnt_reg == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_req     <= 1'b0;
            key_addr    <= 4'd0;
            waiting_reg <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            key_req  <= go;
            key_addr <= go ? addr : 4'd0;
            if (key_req) begin
                waiting_reg <= 1'b1;
                cnt_reg     <= '0;
            end else if (waiting_reg) begin
                if (got || timeout) begin
                    waiting_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/aes_round_seq.sv
// ---------------------------------------------------------------------------
// aes_round_seq
// Round sequencer for the 4x4 near-memory AES PE array. Runs one full
// AES-128 encryption or decryption per accepted start, fetching each round
// key from the key store and driving the shared PE control lines.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, mode : command strobe (IDLE only) and direction (1 = encrypt)
//   busy        : operation in progress (through the DONE cycle)
//   done, err   : one-cycle completion / key-timeout pulses
//   key_req, key_addr, key_vld : round-key fetch handshake
//   pe_en, op_sel, load_psum, shift_in_en, enc_dec : array control lines
// Every output is a register loaded from the decode of the next state, so
// the outputs line up exactly with the state they belong to.
// ---------------------------------------------------------------------------
module aes_round_seq
    import aes_seq_pkg::*;
#(
    parameter int NR     = NR_AES128,
    parameter int KEY_TO = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mode,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       key_req,
    output logic [3:0] key_addr,
    input  logic       key_vld,
    output logic       pe_en,
    output logic [1:0] op_sel,
    output logic       load_psum,
    output logic       shift_in_en,
    output logic       enc_dec
);

    localparam logic [3:0] NR_L = 4'(NR);

    state_t     state_reg, state_next;
    logic [3:0] rnd_reg, rnd_next;   // completed SUBSH steps
    logic [3:0] ks_reg, ks_next;     // completed key additions
    logic       enc_dec_next;
    logic       err_next;
    pe_ctrl_t   ctrl_next;

    logic       fetch_go;
    logic [3:0] fetch_addr;
    logic       key_got;
    logic       key_timeout;

    aes_key_fetch #(
        .KEY_TO (KEY_TO)
    ) u_key_fetch (
        .clk      (clk),
        .rst_n    (rst_n),
        .go       (fetch_go),
        .addr     (fetch_addr),
        .key_vld  (key_vld),
        .key_req  (key_req),
        .key_addr (key_addr),
        .got      (key_got),
        .timeout  (key_timeout)
    );

    // ks never changes on a transition into KREQ, so the current value is
    // the index of the key about to be fetched.
    assign fetch_go   = (state_next == ST_KREQ);
    assign fetch_addr = key_index(enc_dec, ks_reg, NR_L);

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        rnd_next     = rnd_reg;
        ks_next      = ks_reg;
        enc_dec_next = enc_dec;
        err_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_LOAD;
                    enc_dec_next = mode;
                    rnd_next     = 4'd0;
                    ks_next      = 4'd0;
                end
            end
            ST_LOAD:  state_next = ST_KREQ;
            ST_KREQ:  state_next = ST_KWAIT;
            ST_KWAIT: begin
                if (key_got) begin
                    state_next = ST_ARK;
                end else if (key_timeout) begin
                    state_next = ST_IDLE;
                    err_next   = 1'b1;
                end
            end
            ST_ARK: begin
                ks_next = ks_reg + 4'd1;
                // After the last SUBSH the closing key addition finishes the
                // block. Otherwise encryption continues with SUBSH, while
                // decryption follows each middle key addition with an
                // inverse MixColumns (the initial one goes straight to SUBSH).
                if (rnd_reg == NR_L) begin
                    state_next = ST_DONE;
                end else if (enc_dec || (rnd_reg == 4'd0)) begin
                    state_next = ST_SUBSH;
                end else begin
                    state_next = ST_MIXC;
                end
            end
            ST_SUBSH: begin
                rnd_next = rnd_reg + 4'd1;
                // Final encryption round has no MixColumns.
                if (!enc_dec || (rnd_reg == NR_L - 4'd1)) begin
                    state_next = ST_KREQ;
                end else begin
                    state_next = ST_MIXC;
                end
            end
            ST_MIXC:  state_next = enc_dec ? ST_KREQ : ST_SUBSH;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Array control decode of the state being entered
    always_comb begin
        ctrl_next = '0;
        case (state_next)
            ST_LOAD: begin
                ctrl_next.pe_en     = 1'b1;
                ctrl_next.load_psum = 1'b1;
                ctrl_next.op_sel    = OP_NOP;
            end
            ST_ARK: begin
                ctrl_next.pe_en  = 1'b1;
                ctrl_next.op_sel = OP_XOR;
            end
            ST_SUBSH: begin
                ctrl_next.pe_en       = 1'b1;
                ctrl_next.shift_in_en = 1'b1;
                ctrl_next.op_sel      = OP_PASS;
            end
            ST_MIXC: begin
                ctrl_next.pe_en  = 1'b1;
                ctrl_next.op_sel = OP_MIXCOL;
            end
            default: ctrl_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            rnd_reg     <= 4'd0;
            ks_reg      <= 4'd0;
            enc_dec     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            pe_en       <= 1'b0;
            op_sel      <= OP_NOP;
            load_psum   <= 1'b0;
            shift_in_en <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rnd_reg     <= rnd_next;
            ks_reg      <= ks_next;
            enc_dec     <= enc_dec_next;
            busy        <= (state_next != ST_IDLE);
            done        <= (state_next == ST_DONE);
            err         <= err_next;
            pe_en       <= ctrl_next.pe_en;
            op_sel      <= ctrl_next.op_sel;
            load_psum   <= ctrl_next.load_psum;
            shift_in_en <= ctrl_next.shift_in_en;
        end
    end

endmodule

// File: tb/tb_aes_round_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_round_seq
// Scoreboard bench for aes_round_seq. The driver builds each run's step list
// from the AES round order (LOAD, key additions, SubBytes/ShiftRows,
// MixColumns), walks it with the key latency to time-stamp every expected
// event, and queues the events. A monitor on the falling edge pops and
// compares whenever the DUT shows a key request, an array operation, done
// or err. A key-store responder answers requests after L cycles.
// ---------------------------------------------------------------------------
module tb_aes_round_seq;

    localparam int NR     = 10;
    localparam int KEY_TO = 64;

    localparam int K_OP   = 0;
    localparam int K_KEY  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic       busy;
    logic       done;
    logic       err;
    logic       key_req;
    logic [3:0] key_addr;
    logic       key_vld = 1'b0;
    logic       pe_en;
    logic [1:0] op_sel;
    logic       load_psum;
    logic       shift_in_en;
    logic       enc_dec;

    aes_round_seq #(
        .NR     (NR),
        .KEY_TO (KEY_TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .key_req     (key_req),
        .key_addr    (key_addr),
        .key_vld     (key_vld),
        .pe_en       (pe_en),
        .op_sel      (op_sel),
        .load_psum   (load_psum),
        .shift_in_en (shift_in_en),
        .enc_dec     (enc_dec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        int lo;
        int hi;
    } iv_t;
    iv_t busy_q[$];

    // Key-store responder configuration
    int lat_cfg       = 1;
    bit noise_en      = 1'b0;
    int withhold_step = -1;
    int key_count     = 0;

    function automatic string kname(input int k);
        case (k)
            K_OP:    return "op";
            K_KEY:   return "key_addr";
            K_DONE:  return "done";
            default: return "err";
        endcase
    endfunction

    function automatic void push_ev(input int k, input int v, input int at);
        ev_t ev;
        ev.kind = k;
        ev.val  = v;
        ev.at   = at;
        sb.push_back(ev);
    endfunction

    // Expected op value: {enc_dec, load_psum, shift_in_en, op_sel}
    function automatic int op_val(input bit m, input int code);
        return (m ? 16 : 0) + code;
    endfunction

    // Reference: steps of one block, timed from the start edge s.
    // Step codes: -1 LOAD, -2 SubBytes/ShiftRows, -3 MixColumns, >=0 key index.
    task automatic model_run(input bit m, input int lat, input int wh, input int s,
                             output int e, output int mx4);
        int  steps[$];
        int  t;
        int  kidx;
        int  nmix;
        iv_t iv;
        steps.push_back(-1);
        if (m) begin
            steps.push_back(0);
            for (int r = 1; r < NR; r++) begin
                steps.push_back(-2);
                steps.push_back(-3);
                steps.push_back(r);
            end
            steps.push_back(-2);
            steps.push_back(NR);
        end else begin
            steps.push_back(NR);
            for (int r = NR - 1; r >= 1; r--) begin
                steps.push_back(-2);
                steps.push_back(r);
                steps.push_back(-3);
            end
            steps.push_back(-2);
            steps.push_back(0);
        end
        t    = s;
        kidx = 0;
        nmix = 0;
        e    = -1;
        mx4  = -1;
        for (int i = 0; i < steps.size() && e < 0; i++) begin
            case (steps[i])
                -1: begin push_ev(K_OP, op_val(m, 8), t); t++; end
                -2: begin push_ev(K_OP, op_val(m, 7), t); t++; end
                -3: begin
                    nmix++;
                    if (nmix == 4) mx4 = t;
                    push_ev(K_OP, op_val(m, 2), t);
                    t++;
                end
                default: begin
                    push_ev(K_KEY, steps[i], t);
                    if (kidx == wh) begin
                        e = t + 1 + KEY_TO;
                        push_ev(K_ERR, 0, e);
                    end else begin
                        push_ev(K_OP, op_val(m, 1), t + 1 + lat);
                        t = t + 2 + lat;
                    end
                    kidx++;
                end
            endcase
        end
        iv.lo = s;
        if (e < 0) begin
            e = t;
            push_ev(K_DONE, 1, e);
            iv.hi = e;
        end else begin
            iv.hi = e - 1;
        end
        busy_q.push_back(iv);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_quiet_outputs(input string name);
        logic [13:0] v;
        v = {busy, done, err, key_req, key_addr, pe_en, op_sel, load_psum, shift_in_en, enc_dec};
        checks++;
        if (v !== 14'b0) begin
            errors++;
            $display("FAIL %s: got outputs %b, required all zero", name, v);
        end
    endtask

    task automatic do_run(input bit m, input int lat, input bit noise, input int wh);
        int s;
        int e;
        int mx;
        @(negedge clk);
        lat_cfg       = lat;
        noise_en      = noise;
        withhold_step = wh;
        key_count     = 0;
        s = cyc + 1;
        model_run(m, lat, wh, s, e, mx);
        $display("run start=%0d mode=%0d L=%0d withhold=%0d expect_end=%0d", s, m, lat, wh, e);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'($urandom_range(0, 1));
        wait_until(e + 2);
    endtask

    // Key-store responder
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && key_req) begin
                if (key_count == withhold_step) begin
                    key_count++;
                    key_vld = 1'b0;
                end else begin
                    key_count++;
                    key_vld = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                    for (int i = 1; i <= lat_cfg; i++) begin
                        @(negedge clk);
                        key_vld = (i == lat_cfg);
                    end
                    @(negedge clk);
                    key_vld = 1'b0;
                end
            end
        end
    end

    // Monitor
    int  mon_kind;
    int  mon_val;
    bit  mon_have;
    bit  exp_busy;
    ev_t mon_ev;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_have = 1'b1;
            mon_kind = K_OP;
            mon_val  = 0;
            if (key_req) begin
                mon_kind = K_KEY;
                mon_val  = int'(key_addr);
            end else if (pe_en) begin
                mon_kind = K_OP;
                mon_val  = int'({enc_dec, load_psum, shift_in_en, op_sel});
            end else if (done) begin
                mon_kind = K_DONE;
                mon_val  = int'({err, busy});
            end else if (err) begin
                mon_kind = K_ERR;
                mon_val  = int'({done, busy});
            end else begin
                mon_have = 1'b0;
            end

            while (sb.size() > 0 && sb[0].at < cyc) begin
                mon_ev = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_%s: got nothing at cycle %0d, required value %0d",
                         kname(mon_ev.kind), mon_ev.at, mon_ev.val);
            end

            if (mon_have) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_%s at cycle %0d: got value %0d, required no event",
                             kname(mon_kind), cyc, mon_val);
                end else begin
                    mon_ev = sb.pop_front();
                    if (mon_ev.kind != mon_kind || mon_ev.val != mon_val || mon_ev.at != cyc) begin
                        errors++;
                        $display("FAIL %s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                                 kname(mon_ev.kind), kname(mon_kind), mon_val, cyc,
                                 kname(mon_ev.kind), mon_ev.val, mon_ev.at);
                    end
                end
            end

            if (!pe_en) begin
                checks++;
                if ({load_psum, shift_in_en, op_sel} != 4'b0) begin
                    errors++;
                    $display("FAIL idle_lines at cycle %0d: got %b, required 0000",
                             cyc, {load_psum, shift_in_en, op_sel});
                end
            end

            exp_busy = 1'b0;
            foreach (busy_q[i]) begin
                if (cyc >= busy_q[i].lo && cyc <= busy_q[i].hi) exp_busy = 1'b1;
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy at cycle %0d: got %b, required %b", cyc, busy, exp_busy);
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // Driver
    initial begin
        int  s;
        int  e1;
        int  e2;
        int  mx;
        iv_t iv;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet_outputs("reset_state");
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        check_quiet_outputs("reset_ignores_start");
        start = 1'b0;
        mode  = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed: both directions at L = 1, then L = 3 with early key_vld noise
        do_run(1'b1, 1, 1'b0, -1);
        do_run(1'b0, 1, 1'b0, -1);
        do_run(1'b1, 3, 1'b1, -1);
        do_run(1'b0, 3, 1'b1, -1);

        // Randomized directions and latencies
        for (int n = 0; n < 4; n++) begin
            do_run(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 1'b1, -1);
        end

        // Key timeout at key step 5, then a normal run
        do_run(1'b1, 1, 1'b0, 5);
        do_run(1'b1, 1, 1'b0, -1);
        do_run(1'($urandom_range(0, 1)), 2, 1'b1, 5);

        // Reset during the round-4 MixColumns, then a clean run
        @(negedge clk);
        lat_cfg       = 1;
        noise_en      = 1'b0;
        withhold_step = -1;
        key_count     = 0;
        s = cyc + 1;
        model_run(1'b1, 1, -1, s, e1, mx);
        $display("run start=%0d mode=1 L=1 reset_at=%0d", s, mx);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(mx);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet_outputs("mid_run_reset");
        sb.delete();
        iv = busy_q.pop_back();
        iv.hi = mx;
        busy_q.push_back(iv);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_run(1'b1, 1, 1'b0, -1);

        // start held high for 100 cycles: one run, next accepted after DONE
        @(negedge clk);
        lat_cfg       = 1;
        noise_en      = 1'b0;
        withhold_step = -1;
        key_count     = 0;
        s = cyc + 1;
        model_run(1'b1, 1, -1, s, e1, mx);
        model_run(1'b1, 1, -1, e1 + 2, e2, mx);
        $display("held start=%0d first_done=%0d second_start=%0d second_done=%0d",
                 s, e1, e1 + 2, e2);
        mode  = 1'b1;
        start = 1'b1;
        repeat (100) @(negedge clk);
        start = 1'b0;
        wait_until(e2 + 4);

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
